// File: rtl/decode_stage_p.sv
// rtl/decode_stage_p.sv - decode stage: regfile, forwarding, load-use interlock, jump, halt
module decode_stage_p #(
    parameter int DATA_W  = 16,
    parameter int REG_CNT = 16,
    parameter int PC_W    = 16,
    parameter int ZERO_R0 = 1,
    localparam int AW     = $clog2(REG_CNT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       in_inst,
    input  logic [PC_W-1:0]   in_pc,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2:0]        out_alu_op,
    output logic              out_mem_rd,
    output logic              out_mem_wr,
    output logic              out_reg_wr,
    output logic              out_branch,
    output logic [DATA_W-1:0] out_val1,
    output logic [DATA_W-1:0] out_val2,
    output logic [DATA_W-1:0] out_val3,
    output logic [AW-1:0]     out_dst,
    output logic              jump_valid,
    output logic [PC_W-1:0]   jump_addr,
    output logic              halted,
    input  logic              exe_wr_en,
    input  logic [AW-1:0]     exe_wr_addr,
    input  logic [DATA_W-1:0] exe_wr_data,
    input  logic              mem_wr_en,
    input  logic [AW-1:0]     mem_wr_addr,
    input  logic [DATA_W-1:0] mem_wr_data,
    input  logic [AW-1:0]     dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);
    typedef enum logic {ST_RUN, ST_HALTED} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] regs_q [REG_CNT];

    logic              out_valid_q, out_mem_rd_q, out_mem_wr_q, out_reg_wr_q, out_branch_q;
    logic [2:0]        out_alu_q;
    logic [DATA_W-1:0] out_v1_q, out_v2_q, out_v3_q;
    logic [AW-1:0]     out_dst_q;
    logic              jump_valid_q;
    logic [PC_W-1:0]   jump_addr_q;

    logic [3:0]        op;
    logic [3:0]        rt;
    logic [AW-1:0]     rd_a, rs_a;
    logic [DATA_W-1:0] rd_val, rs_val, imm8_sx, rt_zx, one_v, br_tgt_zx;
    logic [PC_W-1:0]   br_tgt, jmp_tgt;

    logic              d_valid, d_mem_rd, d_mem_wr, d_reg_wr, d_branch;
    logic              is_jmp, is_hlt, uses_rd, uses_rs;
    logic [2:0]        d_alu;
    logic [DATA_W-1:0] d_v1, d_v2, d_v3;
    logic              load_use, accept;

    assign op        = in_inst[15:12];
    assign rt        = in_inst[3:0];
    assign rd_a      = in_inst[8 +: AW];
    assign rs_a      = in_inst[4 +: AW];
    assign imm8_sx   = {{(DATA_W-8){in_inst[7]}}, in_inst[7:0]};
    assign rt_zx     = DATA_W'(rt);
    assign one_v     = DATA_W'(1);
    assign br_tgt    = in_pc + {{(PC_W-4){rt[3]}}, rt};
    assign br_tgt_zx = DATA_W'(br_tgt);
    assign jmp_tgt   = in_pc + {{(PC_W-9){in_inst[8]}}, in_inst[8:0]};

    // Operand source: EXE result first, then MEM result, then architectural state
    function automatic logic [DATA_W-1:0] read_op(input logic [AW-1:0] a);
        if (ZERO_R0 != 0 && a == '0)          return '0;
        else if (exe_wr_en && exe_wr_addr == a) return exe_wr_data;
        else if (mem_wr_en && mem_wr_addr == a) return mem_wr_data;
        else                                    return regs_q[a];
    endfunction

    assign rd_val   = read_op(rd_a);
    assign rs_val   = read_op(rs_a);
    assign dbg_data = regs_q[dbg_addr];

    // Instruction decode into the fields handed to EXE
    always_comb begin
        d_valid  = 1'b0; d_alu    = 3'd0; d_mem_rd = 1'b0; d_mem_wr = 1'b0;
        d_reg_wr = 1'b0; d_branch = 1'b0; d_v1 = '0; d_v2 = '0; d_v3 = '0;
        is_jmp   = 1'b0; is_hlt   = 1'b0; uses_rd = 1'b0; uses_rs = 1'b0;
        case (op)
            4'h1, 4'h2, 4'h3, 4'h4: begin
                d_valid = 1'b1; d_alu = 3'(op - 4'h1); d_reg_wr = 1'b1;
                d_v1 = rd_val; d_v2 = rs_val; uses_rd = 1'b1; uses_rs = 1'b1;
            end
            4'h5, 4'h6: begin
                d_valid = 1'b1; d_alu = (op == 4'h6) ? 3'd1 : 3'd0; d_reg_wr = 1'b1;
                d_v1 = rd_val; d_v2 = imm8_sx; uses_rd = 1'b1;
            end
            4'h7: begin
                d_valid = 1'b1; d_reg_wr = 1'b1; d_v1 = rd_val; d_v2 = one_v; uses_rd = 1'b1;
            end
            4'h8: begin
                d_valid = 1'b1; d_reg_wr = 1'b1; d_v1 = imm8_sx;
            end
            4'h9: begin
                d_valid = 1'b1; d_mem_rd = 1'b1; d_reg_wr = 1'b1;
                d_v1 = rs_val; d_v2 = rt_zx; uses_rs = 1'b1;
            end
            4'hA: begin
                d_valid = 1'b1; d_mem_wr = 1'b1; d_v1 = rs_val; d_v2 = rd_val; d_v3 = rt_zx;
                uses_rd = 1'b1; uses_rs = 1'b1;
            end
            4'hC, 4'hD: begin
                d_valid = 1'b1; d_branch = 1'b1; d_alu = (op == 4'hC) ? 3'd5 : 3'd4;
                d_v1 = rd_val; d_v2 = rs_val; d_v3 = br_tgt_zx; uses_rd = 1'b1; uses_rs = 1'b1;
            end
            4'hE:    is_jmp = 1'b1;
            4'hF:    is_hlt = 1'b1;
            default: ;
        endcase
    end

    // Stall when the load sitting in the output register feeds this instruction
    always_comb begin
        load_use = out_valid_q && out_mem_rd_q &&
                   ((uses_rd && out_dst_q == rd_a) || (uses_rs && out_dst_q == rs_a));
        in_ready = (state_q == ST_RUN) && !load_use && !jump_valid_q && (out_ready || !out_valid_q);
        accept   = in_valid && in_ready && !flush;
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_RUN;
        else      state_q <= state_d;
    end

    // FSM next state: an accepted hlt parks the stage until reset
    always_comb begin
        state_d = state_q;
        if (state_q == ST_RUN && accept && is_hlt) state_d = ST_HALTED;
    end

    // FSM outputs
    always_comb begin
        halted = (state_q == ST_HALTED);
    end

    // Register file: both writebacks commit, MEM overrides EXE on the same address
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regs_q <= '{default: '0};
        end else begin
            if (exe_wr_en && !(ZERO_R0 != 0 && exe_wr_addr == '0)) regs_q[exe_wr_addr] <= exe_wr_data;
            if (mem_wr_en && !(ZERO_R0 != 0 && mem_wr_addr == '0)) regs_q[mem_wr_addr] <= mem_wr_data;
        end
    end

    // Output register and jump pulse; flush squashes everything in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0; out_alu_q <= 3'd0; out_mem_rd_q <= 1'b0; out_mem_wr_q <= 1'b0;
            out_reg_wr_q <= 1'b0; out_branch_q <= 1'b0; out_v1_q <= '0; out_v2_q <= '0;
            out_v3_q <= '0; out_dst_q <= '0; jump_valid_q <= 1'b0; jump_addr_q <= '0;
        end else if (flush) begin
            out_valid_q  <= 1'b0;
            jump_valid_q <= 1'b0;
        end else if (accept) begin
            out_valid_q <= d_valid; out_alu_q <= d_alu; out_mem_rd_q <= d_mem_rd;
            out_mem_wr_q <= d_mem_wr; out_reg_wr_q <= d_reg_wr; out_branch_q <= d_branch;
            out_v1_q <= d_v1; out_v2_q <= d_v2; out_v3_q <= d_v3; out_dst_q <= rd_a;
            jump_valid_q <= is_jmp;
            if (is_jmp) jump_addr_q <= jmp_tgt;
        end else begin
            jump_valid_q <= 1'b0;
            if (out_ready) out_valid_q <= 1'b0;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_alu_op = out_alu_q;
    assign out_mem_rd = out_mem_rd_q;
    assign out_mem_wr = out_mem_wr_q;
    assign out_reg_wr = out_reg_wr_q;
    assign out_branch = out_branch_q;
    assign out_val1   = out_v1_q;
    assign out_val2   = out_v2_q;
    assign out_val3   = out_v3_q;
    assign out_dst    = out_dst_q;
    assign jump_valid = jump_valid_q;
    assign jump_addr  = jump_addr_q;
endmodule

// File: tb/tb_decode_stage_p.sv
// tb/tb_decode_stage_p.sv - self-checking bench for decode_stage_p
module tb_decode_stage_p;
    logic        clk, rst, in_valid, in_ready, flush, out_valid, out_ready;
    logic [15:0] in_inst, in_pc;
    logic [2:0]  out_alu_op;
    logic        out_mem_rd, out_mem_wr, out_reg_wr, out_branch, jump_valid, halted;
    logic [15:0] out_val1, out_val2, out_val3, jump_addr, exe_wr_data, mem_wr_data, dbg_data;
    logic [3:0]  out_dst, exe_wr_addr, mem_wr_addr, dbg_addr;
    logic        exe_wr_en, mem_wr_en;

    decode_stage_p #(.DATA_W(16), .REG_CNT(16), .PC_W(16), .ZERO_R0(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
        .in_pc(in_pc), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_alu_op(out_alu_op), .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr),
        .out_reg_wr(out_reg_wr), .out_branch(out_branch), .out_val1(out_val1),
        .out_val2(out_val2), .out_val3(out_val3), .out_dst(out_dst), .jump_valid(jump_valid),
        .jump_addr(jump_addr), .halted(halted), .exe_wr_en(exe_wr_en), .exe_wr_addr(exe_wr_addr),
        .exe_wr_data(exe_wr_data), .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
        .mem_wr_data(mem_wr_data), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          valid;
        logic [2:0]  alu;
        bit          mem_rd, mem_wr, reg_wr, branch;
        logic [15:0] v1, v2, v3;
        logic [3:0]  dst;
    } rec_t;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] mregs [16];

    function automatic logic [15:0] rdreg(int r);
        return (r == 0) ? 16'h0 : mregs[r];
    endfunction

    function automatic logic [15:0] fwd_model(int r, bit ee, int ea, logic [15:0] ed,
                                              bit me, int ma, logic [15:0] md);
        if (r == 0) return 16'h0;
        if (ee && ea == r) return ed;
        if (me && ma == r) return md;
        return mregs[r];
    endfunction

    function automatic rec_t model_decode(logic [15:0] inst, logic [15:0] pc);
        rec_t r;
        int op, rd, rs, rt, s8, srt, t;
        op = int'(inst[15:12]); rd = int'(inst[11:8]); rs = int'(inst[7:4]); rt = int'(inst[3:0]);
        s8 = int'(inst[7:0]);  if (s8 > 127) s8 -= 256;
        srt = (rt > 7) ? rt - 16 : rt;
        r.valid = 0; r.alu = 3'd0; r.mem_rd = 0; r.mem_wr = 0; r.reg_wr = 0; r.branch = 0;
        r.v1 = 16'h0; r.v2 = 16'h0; r.v3 = 16'h0; r.dst = inst[11:8];
        case (op)
            1, 2, 3, 4: begin r.valid = 1; r.alu = 3'(op - 1); r.v1 = rdreg(rd); r.v2 = rdreg(rs); r.reg_wr = 1; end
            5, 6: begin r.valid = 1; r.alu = (op == 6) ? 3'd1 : 3'd0; r.v1 = rdreg(rd); r.v2 = s8[15:0]; r.reg_wr = 1; end
            7: begin r.valid = 1; r.v1 = rdreg(rd); r.v2 = 16'd1; r.reg_wr = 1; end
            8: begin r.valid = 1; r.v1 = s8[15:0]; r.v2 = 16'd0; r.reg_wr = 1; end
            9: begin r.valid = 1; r.v1 = rdreg(rs); r.v2 = 16'(rt); r.mem_rd = 1; r.reg_wr = 1; end
            10: begin r.valid = 1; r.v1 = rdreg(rs); r.v2 = rdreg(rd); r.v3 = 16'(rt); r.mem_wr = 1; end
            12, 13: begin
                r.valid = 1; r.branch = 1; r.alu = (op == 12) ? 3'd5 : 3'd4;
                r.v1 = rdreg(rd); r.v2 = rdreg(rs); t = int'(pc) + srt; r.v3 = t[15:0];
            end
            default: ;
        endcase
        return r;
    endfunction

    function automatic bit is_src(logic [15:0] inst, logic [3:0] r);
        case (int'(inst[15:12]))
            1, 2, 3, 4, 10, 12, 13: return (inst[11:8] == r) || (inst[7:4] == r);
            5, 6, 7:                return inst[11:8] == r;
            9:                      return inst[7:4] == r;
            default:                return 0;
        endcase
    endfunction

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic idle;
        in_valid = 0; flush = 0; exe_wr_en = 0; mem_wr_en = 0; out_ready = 1;
    endtask

    task automatic test_reset;
        rst = 0; idle(); in_inst = 16'h0; in_pc = 16'h0; exe_wr_addr = 0; mem_wr_addr = 0;
        exe_wr_data = 0; mem_wr_data = 0; dbg_addr = 4'd5;
        for (int i = 0; i < 16; i++) mregs[i] = 16'h0;
        tick(); tick(); rst = 1; #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b exp 0", out_valid); end
        checks++; if (jump_valid !== 1'b0) begin errors++; $display("FAIL reset_jump_valid got %0b exp 0", jump_valid); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %0b exp 0", halted); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b exp 1", in_ready); end
        checks++; if (out_val1 !== 16'h0 || dbg_data !== 16'h0) begin errors++; $display("FAIL reset_zero val1=%h dbg=%h exp 0", out_val1, dbg_data); end
    endtask

    task automatic test_regfile;
        int a, b;
        mem_wr_en = 1; mem_wr_addr = 4'd3; mem_wr_data = 16'd5;
        exe_wr_en = 1; exe_wr_addr = 4'd3; exe_wr_data = 16'd9;
        tick(); idle(); mregs[3] = 16'd5; dbg_addr = 4'd3; #1;
        checks++; if (dbg_data !== 16'd5) begin errors++; $display("FAIL regfile_mem_wins got %h exp 0005", dbg_data); end
        for (int i = 0; i < 20; i++) begin
            a = $urandom_range(0, 15); b = (i < 4) ? a : $urandom_range(0, 15);
            exe_wr_en = 1; exe_wr_addr = 4'(a); exe_wr_data = 16'($urandom);
            mem_wr_en = 1; mem_wr_addr = 4'(b); mem_wr_data = 16'($urandom);
            tick();
            if (a != 0) mregs[a] = exe_wr_data;
            if (b != 0) mregs[b] = mem_wr_data;
            idle();
            dbg_addr = 4'(a); #1;
            checks++; if (dbg_data !== rdreg(a)) begin errors++; $display("FAIL regfile_exe r%0d got %h exp %h", a, dbg_data, rdreg(a)); end
            dbg_addr = 4'(b); #1;
            checks++; if (dbg_data !== rdreg(b)) begin errors++; $display("FAIL regfile_mem r%0d got %h exp %h", b, dbg_data, rdreg(b)); end
        end
    endtask

    task automatic test_forwarding;
        int rd, rs;
        logic [15:0] e1, e2;
        for (int i = 0; i < 21; i++) begin
            if (i == 0) begin
                rd = 1; rs = 3;
                exe_wr_en = 1; exe_wr_addr = 4'd3; exe_wr_data = 16'd9;
                mem_wr_en = 1; mem_wr_addr = 4'd3; mem_wr_data = 16'd7;
            end else begin
                rd = $urandom_range(0, 15); rs = $urandom_range(0, 15);
                exe_wr_en = 1'($urandom); exe_wr_addr = 4'($urandom_range(0, 1) ? rd : rs); exe_wr_data = 16'($urandom);
                mem_wr_en = 1'($urandom); mem_wr_addr = 4'($urandom_range(0, 1) ? rd : rs); mem_wr_data = 16'($urandom);
            end
            e1 = fwd_model(rd, exe_wr_en, int'(exe_wr_addr), exe_wr_data, mem_wr_en, int'(mem_wr_addr), mem_wr_data);
            e2 = fwd_model(rs, exe_wr_en, int'(exe_wr_addr), exe_wr_data, mem_wr_en, int'(mem_wr_addr), mem_wr_data);
            in_valid = 1; out_ready = 1; in_inst = {4'h1, 4'(rd), 4'(rs), 4'h0}; #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fwd_in_ready[%0d] got %0b exp 1", i, in_ready); end
            tick();
            if (exe_wr_en && exe_wr_addr != 0) mregs[exe_wr_addr] = exe_wr_data;
            if (mem_wr_en && mem_wr_addr != 0) mregs[mem_wr_addr] = mem_wr_data;
            idle();
            checks++; if (out_valid !== 1'b1 || out_val1 !== e1 || out_val2 !== e2) begin
                errors++; $display("FAIL fwd_operands[%0d] got v=%0b %h %h exp 1 %h %h", i, out_valid, out_val1, out_val2, e1, e2);
            end
        end
        tick();
    endtask

    task automatic test_random_decode;
        bit   occ, acc, exp_rdy;
        rec_t cur, nrec;
        occ = 0; cur = model_decode(16'h0, 16'h0);
        for (int r = 1; r < 16; r++) begin
            mem_wr_en = 1; mem_wr_addr = 4'(r); mem_wr_data = 16'($urandom); tick(); mregs[r] = mem_wr_data;
        end
        idle();
        for (int i = 0; i < 300; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_inst   = {4'($urandom_range(0, 13)), 12'($urandom)};
            if ($urandom_range(0, 3) == 0) in_inst[15:12] = 4'h9;
            if (occ && cur.mem_rd && $urandom_range(0, 1)) begin
                if ($urandom_range(0, 1)) in_inst[11:8] = cur.dst; else in_inst[7:4] = cur.dst;
            end
            in_pc     = 16'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            exp_rdy = (!occ || out_ready) && !(occ && cur.mem_rd && is_src(in_inst, cur.dst));
            checks++; if (in_ready !== exp_rdy) begin errors++; $display("FAIL rand_in_ready[%0d] inst=%h got %0b exp %0b", i, in_inst, in_ready, exp_rdy); end
            acc  = in_valid && exp_rdy;
            nrec = model_decode(in_inst, in_pc);
            tick();
            if (occ && out_ready) occ = 0;
            if (acc && nrec.valid) begin occ = 1; cur = nrec; end
            checks++; if (out_valid !== occ) begin errors++; $display("FAIL rand_out_valid[%0d] got %0b exp %0b", i, out_valid, occ); end
            if (occ) begin
                checks++;
                if (out_alu_op !== cur.alu || out_val1 !== cur.v1 || out_val2 !== cur.v2 ||
                    out_mem_rd !== cur.mem_rd || out_mem_wr !== cur.mem_wr ||
                    out_reg_wr !== cur.reg_wr || out_branch !== cur.branch ||
                    ((cur.mem_wr || cur.branch) && out_val3 !== cur.v3) ||
                    ((cur.reg_wr || cur.mem_rd) && out_dst !== cur.dst)) begin
                    errors++;
                    $display("FAIL rand_fields[%0d] got op=%0d v1=%h v2=%h v3=%h rd=%0b wr=%0b rw=%0b br=%0b dst=%0d exp op=%0d v1=%h v2=%h v3=%h rd=%0b wr=%0b rw=%0b br=%0b dst=%0d",
                             i, out_alu_op, out_val1, out_val2, out_val3, out_mem_rd, out_mem_wr, out_reg_wr, out_branch, out_dst,
                             cur.alu, cur.v1, cur.v2, cur.v3, cur.mem_rd, cur.mem_wr, cur.reg_wr, cur.branch, cur.dst);
                end
            end
        end
        idle(); tick();
    endtask

    task automatic test_load_use;
        idle(); in_valid = 1; in_inst = 16'h9412; #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL lu_ld_ready got %0b exp 1", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_mem_rd !== 1'b1 || out_val1 !== rdreg(1) || out_val2 !== 16'd2 || out_dst !== 4'd4) begin
            errors++; $display("FAIL lu_ld_fields got v=%0b rd=%0b v1=%h v2=%h dst=%0d exp 1 1 %h 0002 4", out_valid, out_mem_rd, out_val1, out_val2, out_dst, rdreg(1));
        end
        in_inst = 16'h1440; #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL lu_stall got %0b exp 0", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lu_bubble got %0b exp 0", out_valid); end
        mem_wr_en = 1; mem_wr_addr = 4'd4; mem_wr_data = 16'hBEEF; #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL lu_resume got %0b exp 1", in_ready); end
        tick(); mregs[4] = 16'hBEEF; idle();
        checks++; if (out_valid !== 1'b1 || out_val1 !== 16'hBEEF || out_val2 !== 16'hBEEF) begin
            errors++; $display("FAIL lu_mem_fwd got v=%0b v1=%h v2=%h exp 1 beef beef", out_valid, out_val1, out_val2);
        end
        tick();
    endtask

    task automatic test_jump;
        int imm, simm, t;
        logic [15:0] exp_addr;
        for (int i = 0; i < 6; i++) begin
            if (i == 0)      begin in_pc = 16'h0010; imm = 9'h1FC; end
            else if (i == 1) begin in_pc = 16'h0002; imm = 9'h1FC; end
            else             begin in_pc = 16'($urandom); imm = $urandom_range(0, 511); end
            simm = (imm > 255) ? imm - 512 : imm;
            t = int'(in_pc) + simm; exp_addr = t[15:0];
            idle(); in_valid = 1; in_inst = {4'hE, 3'($urandom), 9'(imm)}; #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL jmp_ready[%0d] got %0b exp 1", i, in_ready); end
            tick();
            checks++; if (jump_valid !== 1'b1 || jump_addr !== exp_addr || out_valid !== 1'b0) begin
                errors++; $display("FAIL jmp_pulse[%0d] got jv=%0b addr=%h ov=%0b exp 1 %h 0", i, jump_valid, jump_addr, out_valid, exp_addr);
            end
            in_inst = 16'h1120; #1;
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL jmp_block[%0d] got %0b exp 0", i, in_ready); end
            tick();
            checks++; if (jump_valid !== 1'b0 || out_valid !== 1'b0) begin
                errors++; $display("FAIL jmp_after[%0d] got jv=%0b ov=%0b exp 0 0", i, jump_valid, out_valid);
            end
        end
        idle();
    endtask

    task automatic test_stall_flush;
        rec_t e;
        idle(); in_valid = 1; in_inst = 16'h1120; e = model_decode(in_inst, in_pc);
        tick();
        in_valid = 1; in_inst = 16'h82FD; out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready[%0d] got %0b exp 0", i, in_ready); end
            tick();
            checks++; if (out_valid !== 1'b1 || out_val1 !== e.v1 || out_val2 !== e.v2 || out_alu_op !== e.alu || out_dst !== e.dst || out_reg_wr !== 1'b1) begin
                errors++; $display("FAIL stall_hold[%0d] got v=%0b %h %h op=%0d dst=%0d exp 1 %h %h %0d %0d", i, out_valid, out_val1, out_val2, out_alu_op, out_dst, e.v1, e.v2, e.alu, e.dst);
            end
        end
        flush = 1; out_ready = 1; mem_wr_en = 1; mem_wr_addr = 4'd6; mem_wr_data = 16'h55AA;
        tick(); mregs[6] = 16'h55AA; idle(); dbg_addr = 4'd6; #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_squash got %0b exp 0", out_valid); end
        checks++; if (dbg_data !== 16'h55AA) begin errors++; $display("FAIL flush_writeback got %h exp 55aa", dbg_data); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_dropped got %0b exp 0", out_valid); end
        in_valid = 1; in_inst = 16'h82FD;
        tick(); idle();
        checks++; if (out_valid !== 1'b1 || out_val1 !== 16'hFFFD || out_val2 !== 16'h0 || out_alu_op !== 3'd0 || out_reg_wr !== 1'b1 || out_dst !== 4'd2) begin
            errors++; $display("FAIL ldi got v=%0b v1=%h v2=%h op=%0d rw=%0b dst=%0d exp 1 fffd 0000 0 1 2", out_valid, out_val1, out_val2, out_alu_op, out_reg_wr, out_dst);
        end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ldi_drain got %0b exp 0", out_valid); end
    endtask

    task automatic test_halt;
        int r;
        idle(); in_valid = 1; in_inst = 16'h1120; tick();
        in_inst = 16'hF000; #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL hlt_ready got %0b exp 1", in_ready); end
        tick();
        checks++; if (halted !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL hlt_enter got h=%0b ov=%0b exp 1 0", halted, out_valid); end
        in_inst = 16'h8105;
        for (int i = 0; i < 4; i++) begin
            r = $urandom_range(1, 15);
            mem_wr_en = 1; mem_wr_addr = 4'(r); mem_wr_data = 16'($urandom) | 16'h1;
            #1;
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hlt_ready_low[%0d] got %0b exp 0", i, in_ready); end
            tick(); mregs[r] = mem_wr_data; dbg_addr = 4'(r); #1;
            checks++; if (halted !== 1'b1 || out_valid !== 1'b0 || dbg_data !== mregs[r]) begin
                errors++; $display("FAIL hlt_stay[%0d] got h=%0b ov=%0b dbg=%h exp 1 0 %h", i, halted, out_valid, dbg_data, mregs[r]);
            end
        end
        idle(); #2; rst = 0; #1;
        checks++; if (halted !== 1'b0 || out_valid !== 1'b0 || jump_valid !== 1'b0 || dbg_data !== 16'h0 || out_val1 !== 16'h0) begin
            errors++; $display("FAIL async_reset got h=%0b ov=%0b jv=%0b dbg=%h v1=%h exp all 0", halted, out_valid, jump_valid, dbg_data, out_val1);
        end
        #3; rst = 1; tick();
        checks++; if (in_ready !== 1'b1 || halted !== 1'b0) begin errors++; $display("FAIL reset_release got rdy=%0b h=%0b exp 1 0", in_ready, halted); end
    endtask

    initial begin
        test_reset();
        test_regfile();
        test_forwarding();
        test_random_decode();
        test_load_use();
        test_jump();
        test_stall_flush();
        test_halt();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
